// File: rtl/pipe_buf_stage_if.sv
// pipe_buf_stage_if
//   Valid/ready/data handshake bundle that links two pipeline stages.
//   master: drives valid and data, samples ready (the producing side)
//   slave : samples valid and data, drives ready (the consuming side)
// Parameters
//   WIDTH  payload width in bits
interface pipe_buf_stage_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage
//   Generic pipeline buffer register for the boundary between two pipeline stages.
//   It carries an opaque payload and registers it with a 1-cycle latency. A second
//   (skid) entry lets in_ready come straight from a state flop and never from
//   out_ready. It also has a synchronous flush that inserts a bubble, and a
//   saturating counter of back-pressured cycles.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush_i    synchronous flush: drops both held entries and the incoming beat
//   in_if      upstream handshake (slave): valid/data in, ready out
//   out_if     downstream handshake (master): valid/data out, ready in
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out valid and not ready
// Parameters
//   WIDTH      payload width (>=1); must match the WIDTH of both interfaces
//   RESET_VAL  payload value after reset and after a flush
//   CNT_W      width of stall_cnt (>=1)
module pipe_buf_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  pipe_buf_stage_if.slave     in_if,
  pipe_buf_stage_if.master    out_if,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  // The state encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  // Both handshake outputs are decoded from state flops only. This keeps the
  // timing path open between in_* and out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_if.valid & in_ready;
  assign out_fire  = out_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;
  assign occupancy    = state_q;
  assign stall_cnt    = cnt_q;

  always_comb begin
    // NOTE: every variable gets a hold value before any branch. If a path left
    // one unassigned, synthesis would infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    // The stall count does not depend on flush. A blocked cycle is counted even
    // when that same cycle flushes the stage.
    if (out_valid && !out_if.ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush_i) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_if.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_if.data;
          end else if (in_fire) begin
            // Main is still blocked downstream, so the new beat parks behind it.
            state_d = TWO;
            skid_d  = in_if.data;
          end else if (out_fire) begin
            // Main keeps the delivered payload so out_data stays deterministic.
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // NOTE: the payload registers are also reset. RESET_VAL must then show on
  // out_data while the stage is idle, so a reset-less data path would be wrong here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments for all state. Then every flop takes
      // its value from the pre-edge state, whatever order the lines are in.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// tb_pipe_buf_stage
//   Self-checking bench for pipe_buf_stage. Two instances share the same stimulus:
//   dut  (WIDTH=32, CNT_W=16) and dut3 (WIDTH=8, CNT_W=3, for saturation).
//   A queue-based reference model predicts every output.
module tb_pipe_buf_stage;

  localparam logic [31:0] RV  = 32'hDEAD_BEEF;
  localparam logic [7:0]  RV3 = 8'hEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [1:0]  occ,  occ3;
  logic [15:0] scnt;
  logic [2:0]  scnt3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the entries held, the payload last left on the output,
  // and an unbounded stall count.
  logic [31:0] q[$];
  logic [31:0] last_out;
  int          stall;

  pipe_buf_stage_if #(.WIDTH(32)) up_if  ();
  pipe_buf_stage_if #(.WIDTH(32)) dn_if  ();
  pipe_buf_stage_if #(.WIDTH(8))  up3_if ();
  pipe_buf_stage_if #(.WIDTH(8))  dn3_if ();

  assign up_if.valid   = in_valid;
  assign up_if.data    = in_data;
  assign dn_if.ready   = out_ready;
  assign up3_if.valid  = in_valid;
  assign up3_if.data   = in_data[7:0];
  assign dn3_if.ready  = out_ready;

  pipe_buf_stage #(.WIDTH(32), .RESET_VAL(RV), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .in_if     (up_if),
    .out_if    (dn_if),
    .occupancy (occ),
    .stall_cnt (scnt)
  );

  pipe_buf_stage #(.WIDTH(8), .RESET_VAL(RV3), .CNT_W(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .in_if     (up3_if),
    .out_if    (dn3_if),
    .occupancy (occ3),
    .stall_cnt (scnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_out = RV;
    stall    = 0;
  endtask

  // Compares every output of both instances against the model.
  task automatic check_all(input string tag);
    logic [31:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : last_out;
    check({tag, ".occ"},    64'(occ),          64'(q.size()));
    check({tag, ".ovalid"}, 64'(dn_if.valid),  64'(q.size() > 0));
    check({tag, ".iready"}, 64'(up_if.ready),  64'(q.size() < 2));
    check({tag, ".odata"},  64'(dn_if.data),   64'(exp_data));
    check({tag, ".stall"},  64'(scnt),         64'(stall));
    check({tag, ".occ3"},   64'(occ3),         64'(q.size()));
    check({tag, ".odata3"}, 64'(dn3_if.data),  64'(exp_data[7:0]));
    check({tag, ".stall3"}, 64'(scnt3),        64'((stall > 7) ? 7 : stall));
  endtask

  // Applies one cycle of stimulus. The model advances on the pre-edge state,
  // then all outputs are checked 1 time unit after the edge.
  task automatic tick(input string tag, input logic v, input logic [31:0] d,
                      input logic r, input logic f);
    bit do_in, do_out;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    do_in  = v && (q.size() < 2);
    do_out = r && (q.size() > 0);
    if ((q.size() > 0) && !r) stall++;
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      last_out = RV;
    end else begin
      if (do_out) last_out = q.pop_front();
      if (do_in)  q.push_back(d);
    end
    check_all(tag);
  endtask

  initial begin
    int s0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    check("reset.odata_const", 64'(dn_if.data), 64'(RV));
    rst_n = 1'b1;
    #(1);

    // 1. Single beat
    tick("t1", 1'b1, 32'hA5, 1'b1, 1'b0);
    check("t1.ovalid_const", 64'(dn_if.valid), 64'd1);
    check("t1.odata_const",  64'(dn_if.data),  64'hA5);
    check("t1.occ_const",    64'(occ),         64'd1);
    tick("t1.drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // 2. Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      tick("t2", 1'b1, 32'(i), 1'b1, 1'b0);
      check("t2.odata_const",  64'(dn_if.data),  64'(i));
      check("t2.iready_const", 64'(up_if.ready), 64'd1);
    end
    tick("t2.drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // 3. Back-pressure
    s0 = stall;
    tick("t3.a", 1'b1, 32'h11, 1'b0, 1'b0);
    check("t3.occ1", 64'(occ), 64'd1);
    tick("t3.b", 1'b1, 32'h22, 1'b0, 1'b0);
    check("t3.occ2", 64'(occ), 64'd2);
    check("t3.iready0", 64'(up_if.ready), 64'd0);
    tick("t3.c", 1'b1, 32'h33, 1'b0, 1'b0);
    check("t3.occ2b", 64'(occ), 64'd2);
    check("t3.stall2", 64'(scnt), 64'(s0 + 2));
    check("t3.out11", 64'(dn_if.data), 64'h11);
    tick("t3.d", 1'b1, 32'h33, 1'b1, 1'b0);
    check("t3.out22", 64'(dn_if.data), 64'h22);
    tick("t3.e", 1'b1, 32'h33, 1'b1, 1'b0);
    check("t3.out33", 64'(dn_if.data), 64'h33);
    tick("t3.f", 1'b0, 32'h0, 1'b1, 1'b0);
    check("t3.empty", 64'(occ), 64'd0);

    // 4. Flush with two entries held and an incoming beat
    tick("t4.a", 1'b1, 32'hA1, 1'b0, 1'b0);
    tick("t4.b", 1'b1, 32'hA2, 1'b0, 1'b0);
    s0 = stall;
    tick("t4.flush", 1'b1, 32'h77, 1'b0, 1'b1);
    check("t4.occ0",    64'(occ),         64'd0);
    check("t4.ovalid0", 64'(dn_if.valid), 64'd0);
    check("t4.rv",      64'(dn_if.data),  64'(RV));
    check("t4.iready1", 64'(up_if.ready), 64'd1);
    check("t4.stall_kept", 64'(scnt), 64'(s0 + 1));
    tick("t4.after", 1'b0, 32'h0, 1'b1, 1'b0);
    check("t4.no77", 64'(dn_if.valid), 64'd0);

    // 6. Asynchronous reset mid-cycle with two entries held
    tick("t6.a", 1'b1, 32'hB1, 1'b0, 1'b0);
    tick("t6.b", 1'b1, 32'hB2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    check("t6.occ0", 64'(occ), 64'd0);
    #2;
    rst_n = 1'b1;
    tick("t6.first", 1'b1, 32'hC3, 1'b1, 1'b0);
    check("t6.accepted", 64'(dn_if.data), 64'hC3);
    tick("t6.drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // 5. Saturation of the narrow counter: one entry held, 12 blocked cycles
    tick("t5.load", 1'b1, 32'hD4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick("t5", 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5.sat7",  64'(scnt3), 64'd7);
    check("t5.wide",  64'(scnt),  64'd12);
    tick("t5.drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
